// File: rtl/pb_dip_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pb_dip_conditioner
// Purpose  : Two-flop synchronisers and counter debouncers for two pushbuttons
//            and one DIP switch, plus one-cycle press pulses on the buttons.
// Revision : 1.0 - initial release
// ============================================================================
module pb_dip_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pb_raw,
    input  logic       dip_raw,
    output logic [1:0] pb_clean,
    output logic       dip_clean,
    output logic [1:0] pb_press
);

    localparam int              c_NUM_CH  = 3;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [c_NUM_CH-1:0] w_raw;
    logic [c_NUM_CH-1:0] w_clean;
    logic [1:0]          w_press;

    // Channel order: pb_raw[0], pb_raw[1], dip_raw
    assign w_raw = {dip_raw, pb_raw};

    generate
        for (genvar i = 0; i < c_NUM_CH; i++) begin : g_chan
            logic             r_sync1;
            logic             r_sync2;
            logic             r_clean;
            logic [CNT_W-1:0] r_cnt;
            logic             w_differ;
            logic             w_load;

            assign w_differ = (r_sync2 != r_clean);
            assign w_load   = w_differ && (r_cnt == c_CNT_MAX);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= w_raw[i];
                    r_sync2 <= r_sync1;
                end
            end

            // Any return of the synchronised level to the clean level restarts the count
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt   <= '0;
                    r_clean <= 1'b0;
                end else if (!w_differ) begin
                    r_cnt   <= '0;
                end else if (w_load) begin
                    r_cnt   <= '0;
                    r_clean <= r_sync2;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            assign w_clean[i] = r_clean;

            if (i < 2) begin : g_press
                logic r_press;

                // Pulse coincides with the edge on which the clean level rises
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_press <= 1'b0;
                    end else begin
                        r_press <= w_load && r_sync2;
                    end
                end

                assign w_press[i] = r_press;
            end
        end
    endgenerate

    assign pb_clean  = w_clean[1:0];
    assign dip_clean = w_clean[2];
    assign pb_press  = w_press;

endmodule
`default_nettype wire

// File: tb/tb_pb_dip_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_dip_conditioner
// Purpose  : Directed and random checks of pb_dip_conditioner against a
//            sample-history model (clean flips after D consecutive differing samples).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_dip_conditioner;

    localparam int c_D     = 4;
    localparam int c_CNT_W = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pb_raw;
    logic       dip_raw;
    logic [1:0] pb_clean;
    logic       dip_clean;
    logic [1:0] pb_press;

    int n_cmp = 0;
    int n_mis = 0;

    pb_dip_conditioner #(
        .DEBOUNCE_CYCLES (c_D),
        .CNT_W           (c_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb_raw    (pb_raw),
        .dip_raw   (dip_raw),
        .pb_clean  (pb_clean),
        .dip_clean (dip_clean),
        .pb_press  (pb_press)
    );

    always #5 clk = ~clk;

    // Reference: hist[c][j] is the raw level sampled j+1 edges ago. The DUT sees
    // a level two edges after sampling, so clean flips when samples 2..D+1 edges
    // old all disagree with the current clean level.
    logic [c_D:0] hist [3];
    logic [2:0]   m_clean;
    logic [1:0]   m_press;
    logic [2:0]   m_flip;

    always_comb begin
        m_flip = '0;
        for (int c = 0; c < 3; c++) begin
            m_flip[c] = (hist[c][c_D:1] == {c_D{~m_clean[c]}});
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) hist[c] <= '0;
            m_clean <= '0;
            m_press <= '0;
        end else begin
            hist[0] <= {hist[0][c_D-1:0], pb_raw[0]};
            hist[1] <= {hist[1][c_D-1:0], pb_raw[1]};
            hist[2] <= {hist[2][c_D-1:0], dip_raw};
            m_clean <= m_clean ^ m_flip;
            m_press <= m_flip[1:0] & ~m_clean[1:0];
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".clean"}, {5'd0, dip_clean, pb_clean}, {5'd0, m_clean});
        check({tag, ".press"}, {6'd0, pb_press}, {6'd0, m_press});
    endtask

    // One clock: sample #1 after the rising edge, return at the falling edge
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    task automatic quiet();
        pb_raw  = 2'b00;
        dip_raw = 1'b0;
        for (int k = 0; k < c_D + 4; k++) tick("quiet");
    endtask

    initial begin
        int first_pb0;
        int first_pb1;
        int first_dip;
        int first_press;
        int npress;
        int hold;

        rst_n   = 1'b0;
        pb_raw  = 2'b11;
        dip_raw = 1'b1;
        @(negedge clk);
        #1;
        check("reset_hold", {3'd0, pb_press, dip_clean, pb_clean}, 8'h00);
        @(negedge clk);

        // Release with all inputs high: expect rise exactly c_D+2 edges later
        rst_n       = 1'b1;
        first_pb0   = 0;
        first_dip   = 0;
        first_press = 0;
        npress      = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("rel");
            if (first_pb0 == 0 && pb_clean == 2'b11) first_pb0 = k;
            if (first_dip == 0 && dip_clean) first_dip = k;
            if (pb_press == 2'b11) begin
                npress++;
                if (first_press == 0) first_press = k;
            end
        end
        check("rel_pb_edge", 8'(first_pb0), 8'(c_D + 2));
        check("rel_dip_edge", 8'(first_dip), 8'(c_D + 2));
        check("rel_press_edge", 8'(first_press), 8'(c_D + 2));
        check("rel_press_count", 8'(npress), 8'd1);

        // Asynchronous assertion mid-cycle with outputs high
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", {3'd0, pb_press, dip_clean, pb_clean}, 8'h00);
        check_model("async_model");
        @(negedge clk);
        rst_n = 1'b1;
        quiet();

        // Clean press and release on pb[0]
        pb_raw[0] = 1'b1;
        first_pb0 = 0;
        npress    = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("press");
            if (first_pb0 == 0 && pb_clean[0]) first_pb0 = k;
            if (pb_press[0]) npress++;
        end
        check("press_edge", 8'(first_pb0), 8'(c_D + 2));
        check("press_pulses", 8'(npress), 8'd1);
        pb_raw[0] = 1'b0;
        first_pb0 = 0;
        npress    = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("release");
            if (first_pb0 == 0 && !pb_clean[0]) first_pb0 = k;
            if (pb_press[0]) npress++;
        end
        check("release_edge", 8'(first_pb0), 8'(c_D + 2));
        check("release_pulses", 8'(npress), 8'd0);

        // Glitch on pb[1] one cycle shorter than the debounce window
        quiet();
        npress = 0;
        for (int k = 1; k <= 12; k++) begin
            pb_raw[1] = (k <= c_D - 1);
            tick("glitch");
            if (pb_clean[1] || pb_press[1]) npress++;
        end
        check("glitch_activity", 8'(npress), 8'd0);

        // Bounce on dip: last 0 seen at edge 5, so rise at edge 5+c_D
        quiet();
        first_dip = 0;
        for (int k = 1; k <= 14; k++) begin
            dip_raw = (k != 3);
            tick("bounce");
            if (first_dip == 0 && dip_clean) first_dip = k;
        end
        check("bounce_edge", 8'(first_dip), 8'(5 + c_D));

        // Independence: pb[0] and dip together, pb[1] untouched
        quiet();
        pb_raw    = 2'b01;
        dip_raw   = 1'b1;
        first_pb0 = 0;
        first_pb1 = 0;
        first_dip = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("indep");
            if (first_pb0 == 0 && pb_clean[0]) first_pb0 = k;
            if (first_pb1 == 0 && pb_clean[1]) first_pb1 = k;
            if (first_dip == 0 && dip_clean) first_dip = k;
        end
        check("indep_pb0", 8'(first_pb0), 8'(c_D + 2));
        check("indep_dip", 8'(first_dip), 8'(c_D + 2));
        check("indep_pb1", 8'(first_pb1), 8'd0);

        // Reset while pb[0] count is at 2, then full restart
        quiet();
        pb_raw[0] = 1'b1;
        for (int k = 1; k <= 4; k++) tick("midcnt");
        rst_n = 1'b0;
        #1;
        check("midcnt_clear", {3'd0, pb_press, dip_clean, pb_clean}, 8'h00);
        @(negedge clk);
        rst_n     = 1'b1;
        first_pb0 = 0;
        npress    = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("midcnt_rel");
            if (first_pb0 == 0 && pb_clean[0]) first_pb0 = k;
            if (pb_press[0]) npress++;
        end
        check("midcnt_edge", 8'(first_pb0), 8'(c_D + 2));
        check("midcnt_pulses", 8'(npress), 8'd1);

        // Random levels with random hold times and occasional resets
        for (int it = 0; it < 400; it++) begin
            pb_raw  = 2'($urandom_range(0, 3));
            dip_raw = 1'($urandom_range(0, 1));
            hold    = $urandom_range(1, 2 * c_D);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand_rst", {3'd0, pb_press, dip_clean, pb_clean}, 8'h00);
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int k = 0; k < hold; k++) tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
